// File: rtl/scl180_id_pkg.sv
// Shared types and constants for the SCL180 user-ID register and its serializer.
// Holds the readout state encoding, the default tie-off ID and the width check.
package scl180_id_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_e;

    localparam logic [63:0] DEFAULT_ID = 64'h0;

    function automatic bit width_ok(input int width);
        return (width >= 2) && (width <= 64);
    endfunction

endpackage

// File: rtl/scl180_id_serializer.sv
// Streams a snapshot of the ID one bit per cycle, framed by busy/sdo_valid/rd_done.
// All outputs are registered; the snapshot decouples the stream from later overrides.
module scl180_id_serializer
    import scl180_id_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] id,
    input  logic             rd_req,
    output logic             busy,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             rd_done
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, sdo_d, valid_d, done_d;

    function automatic logic pick(input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] c);
        return LSB_FIRST ? v[c] : v[LAST - c];
    endfunction

    // NOTE: combinational logic uses blocking '=' and assigns every output a default first,
    // so no latch is inferred and later statements can read values set earlier (cnt_d below).
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        sdo_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = SHIFT;
                    snap_d  = id;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    sdo_d   = pick(id, '0);
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    valid_d = 1'b1;
                    sdo_d   = pick(snap_q, cnt_d);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            sdo       <= sdo_d;
            sdo_valid <= valid_d;
            rd_done   <= done_d;
        end
    end

endmodule

// File: rtl/scl180_user_id_reg.sv
// Programmable user-ID register: reset-loaded ID, firmware override gated by a sticky lock,
// parallel output and on-request serial readout through scl180_id_serializer.
module scl180_user_id_reg
    import scl180_id_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] ID_VALUE  = WIDTH'(DEFAULT_ID),
    parameter bit               LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [WIDTH-1:0] id_out,
    input  logic             rd_req,
    output logic             busy,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             rd_done,
    input  logic             ovr_we,
    input  logic [WIDTH-1:0] ovr_data,
    input  logic             lock,
    output logic             locked
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("scl180_user_id_reg: WIDTH must be in 2..64");
    end

    logic [WIDTH-1:0] id_reg;

    // A write in the same cycle as lock still lands: the gate looks at the old locked value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_reg <= ID_VALUE;
            locked <= 1'b0;
        end else begin
            if (ovr_we && !locked) id_reg <= ovr_data;
            if (lock)              locked <= 1'b1;
        end
    end

    assign id_out = id_reg;

    scl180_id_serializer #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .id        (id_reg),
        .rd_req    (rd_req),
        .busy      (busy),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .rd_done   (rd_done)
    );

endmodule

// File: tb/tb_scl180_user_id_reg.sv
// Scoreboard bench for scl180_user_id_reg: four instances cover LSB/MSB order and widths 2, 32, 64.
// Expected serial bits are queued when a readout is requested and popped as sdo_valid bits arrive.
module tb_scl180_user_id_reg;

    localparam logic [31:0] ID32 = 32'hA5C3_0F96;
    localparam logic [1:0]  ID2  = 2'b10;
    localparam logic [63:0] ID64 = 64'h0123_4567_89AB_CDEF;
    localparam int WID  [4] = '{32, 32, 2, 64};
    localparam bit LSBF [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  rd_req = '0;
    logic [3:0]  busy, sdo, sdo_valid, rd_done, locked;
    logic        ovr_we = 1'b0;
    logic [31:0] ovr_data = '0;
    logic        lock = 1'b0;
    logic [31:0] id0, id1;
    logic [1:0]  id2;
    logic [63:0] id3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc [4];
    int done_cnt  [4] = '{0, 0, 0, 0};
    int done_exp  [4] = '{0, 0, 0, 0};
    logic [63:0] model_id [4];
    bit exp_q [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scl180_user_id_reg #(.WIDTH(32), .ID_VALUE(ID32), .LSB_FIRST(1'b1)) u_lsb32 (
        .clk(clk), .resetn(resetn), .id_out(id0), .rd_req(rd_req[0]), .busy(busy[0]),
        .sdo(sdo[0]), .sdo_valid(sdo_valid[0]), .rd_done(rd_done[0]), .ovr_we(ovr_we),
        .ovr_data(ovr_data), .lock(lock), .locked(locked[0]));
    scl180_user_id_reg #(.WIDTH(32), .ID_VALUE(ID32), .LSB_FIRST(1'b0)) u_msb32 (
        .clk(clk), .resetn(resetn), .id_out(id1), .rd_req(rd_req[1]), .busy(busy[1]),
        .sdo(sdo[1]), .sdo_valid(sdo_valid[1]), .rd_done(rd_done[1]), .ovr_we(1'b0),
        .ovr_data(32'h0), .lock(1'b0), .locked(locked[1]));
    scl180_user_id_reg #(.WIDTH(2), .ID_VALUE(ID2), .LSB_FIRST(1'b1)) u_w2 (
        .clk(clk), .resetn(resetn), .id_out(id2), .rd_req(rd_req[2]), .busy(busy[2]),
        .sdo(sdo[2]), .sdo_valid(sdo_valid[2]), .rd_done(rd_done[2]), .ovr_we(1'b0),
        .ovr_data(2'b00), .lock(1'b0), .locked(locked[2]));
    scl180_user_id_reg #(.WIDTH(64), .ID_VALUE(ID64), .LSB_FIRST(1'b0)) u_w64 (
        .clk(clk), .resetn(resetn), .id_out(id3), .rd_req(rd_req[3]), .busy(busy[3]),
        .sdo(sdo[3]), .sdo_valid(sdo_valid[3]), .rd_done(rd_done[3]), .ovr_we(1'b0),
        .ovr_data(64'h0), .lock(1'b0), .locked(locked[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every valid serial bit must match the next queued expectation; bits with nothing queued are extra.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (sdo_valid[k]) begin
                if (exp_q[k].size() == 0) check($sformatf("extra_bit_%0d", k), 64'(1), 64'(0));
                else check($sformatf("sdo_%0d", k), 64'(sdo[k]), 64'(exp_q[k].pop_front()));
            end
            if (rd_done[k]) done_cnt[k]++;
        end
    end

    task automatic push_bits(input int k);
        for (int i = 0; i < WID[k]; i++)
            exp_q[k].push_back(LSBF[k] ? model_id[k][i] : model_id[k][WID[k]-1-i]);
    endtask

    // Called with the DUT idle; returns in the first shift cycle.
    task automatic start_read(input int k);
        push_bits(k);
        rd_req[k] = 1'b1;
        tick();
        rd_req[k] = 1'b0;
        start_cyc[k] = cyc;
        check($sformatf("busy_start_%0d", k), 64'(busy[k]), 64'(1));
        check($sformatf("valid_start_%0d", k), 64'(sdo_valid[k]), 64'(1));
    endtask

    // Waits (bounded) for rd_done, checks its latency and that busy drops one cycle later.
    task automatic finish_read(input int k);
        int lat = 0;
        while (!rd_done[k] && lat < WID[k] + 6) begin
            tick();
            lat++;
        end
        done_exp[k]++;
        check($sformatf("done_latency_%0d", k), 64'(cyc - start_cyc[k]), 64'(WID[k]));
        check($sformatf("done_busy_%0d", k), 64'(busy[k]), 64'(1));
        check($sformatf("done_valid_%0d", k), 64'(sdo_valid[k]), 64'(0));
        tick();
        check($sformatf("busy_after_%0d", k), 64'(busy[k]), 64'(0));
        check($sformatf("done_single_%0d", k), 64'(rd_done[k]), 64'(0));
        check($sformatf("queue_drained_%0d", k), 64'(exp_q[k].size()), 64'(0));
    endtask

    task automatic read_one(input int k);
        start_read(k);
        finish_read(k);
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        model_id[0] = 64'(ID32);
        tick();
    endtask

    initial begin
        model_id[0] = 64'(ID32);
        model_id[1] = 64'(ID32);
        model_id[2] = 64'(ID2);
        model_id[3] = ID64;

        // Reset state, observed while reset is held and after release.
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(sdo_valid), 64'(0));
        check("rst_sdo", 64'(sdo), 64'(0));
        check("rst_done", 64'(rd_done), 64'(0));
        resetn = 1'b1;
        tick();
        check("rst_id0", 64'(id0), 64'(ID32));
        check("rst_id1", 64'(id1), 64'(ID32));
        check("rst_id2", 64'(id2), 64'(ID2));
        check("rst_id3", id3, ID64);
        check("rst_locked", 64'(locked), 64'(0));

        read_one(0);
        read_one(1);

        // Override at bit 5: id_out follows next cycle, stream keeps the snapshot.
        start_read(0);
        repeat (5) tick();
        ovr_we = 1'b1;
        ovr_data = 32'h1234_5678;
        tick();
        ovr_we = 1'b0;
        model_id[0] = 64'h1234_5678;
        check("ovr_id", 64'(id0), 64'h1234_5678);
        finish_read(0);
        read_one(0);

        // Lock with same-cycle write, then a blocked write.
        ovr_we = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        lock = 1'b1;
        tick();
        ovr_we = 1'b0;
        lock = 1'b0;
        model_id[0] = 64'hDEAD_BEEF;
        check("lock_id", 64'(id0), 64'hDEAD_BEEF);
        check("lock_set", 64'(locked[0]), 64'(1));
        ovr_we = 1'b1;
        ovr_data = 32'h0;
        tick();
        ovr_we = 1'b0;
        tick();
        check("locked_id", 64'(id0), 64'hDEAD_BEEF);
        check("lock_sticky", 64'(locked[0]), 64'(1));
        read_one(0);
        pulse_reset();
        check("unlock_rst", 64'(locked[0]), 64'(0));
        check("unlock_id", 64'(id0), 64'(ID32));

        // rd_req held high: exactly two readouts with one IDLE cycle between them.
        push_bits(0);
        push_bits(0);
        rd_req[0] = 1'b1;
        repeat (34) tick();
        check("held_idle_gap", 64'(busy[0]), 64'(0));
        tick();
        rd_req[0] = 1'b0;
        check("held_restart", 64'(busy[0]), 64'(1));
        done_exp[0]++;
        start_cyc[0] = cyc;
        finish_read(0);
        repeat (3) tick();
        check("held_no_third", 64'(busy[0]), 64'(0));
        check("held_done_cnt", 64'(done_cnt[0]), 64'(done_exp[0]));

        // Reset at bit 10 abandons the stream immediately.
        start_read(0);
        repeat (10) tick();
        resetn = 1'b0;
        #1;
        check("midrst_valid", 64'(sdo_valid[0]), 64'(0));
        check("midrst_busy", 64'(busy[0]), 64'(0));
        check("midrst_done", 64'(rd_done[0]), 64'(0));
        exp_q[0].delete();
        tick();
        resetn = 1'b1;
        repeat (WID[0] + 4) tick();
        read_one(0);

        read_one(2);
        read_one(3);
        read_one(2);

        repeat (4) tick();
        for (int k = 0; k < 4; k++)
            check($sformatf("done_total_%0d", k), 64'(done_cnt[k]), 64'(done_exp[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
